// File: rtl/bidirectional_piso.sv
// Parallel-in, serial-out shifter with per-frame MSB/LSB-first direction.
// Valid/ready load, bit counter, frame-last flag, back-to-back reload.
module bidirectional_piso #(
   parameter int MSB = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [MSB-1:0] load_data,
   input  logic           load_dir,
   input  logic           load_valid,
   output logic           load_ready,
   input  logic           en,
   output logic           sout,
   output logic           sout_valid,
   output logic           last,
   output logic           busy
);

   localparam int CW = ($clog2(MSB) < 1) ? 1 : $clog2(MSB);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   localparam logic [CW-1:0] CNT_LOAD = CW'(MSB - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [0:0]     state;
   logic [MSB-1:0] sreg;
   logic           dir_q;
   logic [CW-1:0]  cnt;

   logic in_shift;
   logic final_bit;
   logic advance;
   logic accept;

   assign in_shift  = (state == SHIFT);
   assign final_bit = in_shift && (cnt == '0);
   assign advance   = in_shift && en;

   // a new word fits when idle or when the current frame retires this edge
   assign load_ready = !in_shift || (final_bit && en);
   assign accept     = load_valid && load_ready;

   // frame state: enter on accept, leave after the final enabled bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else if (accept) begin
         state <= SHIFT;
      end else if (advance && final_bit) begin
         state <= IDLE;
      end
   end

   // word, direction and bit counter; counter parks at zero on the last bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg  <= '0;
         dir_q <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         sreg  <= load_data;
         dir_q <= load_dir;
         cnt   <= CNT_LOAD;
      end else if (advance) begin
         if (dir_q) begin
            sreg <= {1'b0, sreg[MSB-1:1]};
         end else begin
            sreg <= {sreg[MSB-2:0], 1'b0};
         end
         if (!final_bit) begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

   // serial outputs are a gated mux of registered state
   always_comb begin
      sout       = 1'b0;
      sout_valid = 1'b0;
      last       = 1'b0;
      busy       = 1'b0;
      if (in_shift) begin
         sout       = dir_q ? sreg[0] : sreg[MSB-1];
         sout_valid = 1'b1;
         last       = final_bit;
         busy       = 1'b1;
      end
   end

endmodule

// File: tb/tb_bidirectional_piso.sv
// Self-checking bench for bidirectional_piso (MSB=4).
// Directed plan scenarios plus a randomized run against a bit-queue model.
module tb_bidirectional_piso;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] load_data;
   logic         load_dir;
   logic         load_valid;
   logic         load_ready;
   logic         en;
   logic         sout;
   logic         sout_valid;
   logic         last;
   logic         busy;

   int total  = 0;
   int passed = 0;

   bidirectional_piso #(.MSB(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_data  (load_data),
      .load_dir   (load_dir),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .en         (en),
      .sout       (sout),
      .sout_valid (sout_valid),
      .last       (last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // i-th transmitted bit of a word: MSB-first when d=0, LSB-first when d=1
   function automatic logic frame_bit(input logic [W-1:0] w, input logic d,
                                      input int i);
      return d ? w[i] : w[W-1-i];
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] got;
      rst = 1'b1;
      load_valid = 1'b0;
      load_data = '0;
      load_dir = 1'b0;
      en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      got = {sout, sout_valid, last, busy, load_ready};
      total++;
      if (got !== 5'b00001)
         $display("FAIL reset_outputs: got %b want 00001", got);
      else passed++;
      next_cycle();
      rst = 1'b0;
      next_cycle();
      @(negedge clk);
      got = {sout, sout_valid, last, busy, load_ready};
      total++;
      if (got !== 5'b00001)
         $display("FAIL idle_after_reset: got %b want 00001", got);
      else passed++;
      next_cycle();
   endtask

   task automatic test_msb_first();
      logic [W-1:0] w = 4'b1001;
      logic [3:0] got, exp;
      load_data = w;
      load_dir = 1'b0;
      load_valid = 1'b1;
      en = 1'b1;
      @(negedge clk);
      total++;
      if (load_ready !== 1'b1)
         $display("FAIL msb_accept_ready: got %b want 1", load_ready);
      else passed++;
      next_cycle();
      load_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         got = {sout, sout_valid, last, busy};
         exp = {frame_bit(w, 1'b0, i), 1'b1, (i == W - 1), 1'b1};
         total++;
         if (got !== exp)
            $display("FAIL msb_bit%0d: got %b want %b", i, got, exp);
         else passed++;
         next_cycle();
      end
      @(negedge clk);
      total++;
      if ({busy, load_ready, sout_valid} !== 3'b010)
         $display("FAIL msb_frame_end: got %b want 010",
                  {busy, load_ready, sout_valid});
      else passed++;
      next_cycle();
   endtask

   task automatic test_lsb_first();
      logic [W-1:0] w = 4'b1101;
      int n_valid = 0;
      int idx = 0;
      load_data = w;
      load_dir = 1'b1;
      load_valid = 1'b1;
      en = 1'b1;
      next_cycle();
      load_valid = 1'b0;
      load_dir = 1'b0;
      for (int c = 0; c < W + 3; c++) begin
         @(negedge clk);
         if (sout_valid === 1'b1) begin
            n_valid++;
            total++;
            if (idx >= W || sout !== frame_bit(w, 1'b1, idx))
               $display("FAIL lsb_bit%0d: got %b want %b", idx, sout,
                        frame_bit(w, 1'b1, idx % W));
            else passed++;
            idx++;
         end
         next_cycle();
      end
      total++;
      if (n_valid != W)
         $display("FAIL lsb_valid_cycles: got %0d want %0d", n_valid, W);
      else passed++;
   endtask

   task automatic test_pause();
      logic [W-1:0] w = 4'b1010;
      logic en_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int idx = 0;
      logic [2:0] got, exp;
      load_data = w;
      load_dir = 1'b0;
      load_valid = 1'b1;
      en = 1'b1;
      next_cycle();
      load_valid = 1'b0;
      for (int c = 0; c < 7; c++) begin
         en = en_pat[c];
         @(negedge clk);
         got = {sout, sout_valid, last};
         exp = {frame_bit(w, 1'b0, idx), 1'b1, (idx == W - 1)};
         total++;
         if (got !== exp)
            $display("FAIL pause_cycle%0d: got %b want %b", c, got, exp);
         else passed++;
         if (en) idx++;
         next_cycle();
      end
      en = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, sout_valid} !== 2'b00)
         $display("FAIL pause_frame_end: got %b want 00", {busy, sout_valid});
      else passed++;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] w0 = 4'b1001;
      logic [W-1:0] w1 = 4'b0110;
      logic [2:0] got, exp;
      logic eb;
      load_data = w0;
      load_dir = 1'b0;
      load_valid = 1'b1;
      en = 1'b1;
      next_cycle();
      load_data = w1;
      for (int c = 0; c < 2 * W; c++) begin
         if (c == W) load_valid = 1'b0;
         @(negedge clk);
         eb = (c < W) ? frame_bit(w0, 1'b0, c) : frame_bit(w1, 1'b0, c - W);
         got = {sout, sout_valid, load_ready};
         exp = {eb, 1'b1, ((c % W) == W - 1)};
         total++;
         if (got !== exp)
            $display("FAIL b2b_cycle%0d: got %b want %b", c, got, exp);
         else passed++;
         next_cycle();
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0)
         $display("FAIL b2b_idle: got %b want 0", busy);
      else passed++;
      next_cycle();
   endtask

   task automatic test_mid_frame();
      logic [W-1:0] w = 4'b1001;
      logic [2:0] got, exp;
      logic [4:0] r;
      load_data = w;
      load_dir = 1'b0;
      load_valid = 1'b1;
      en = 1'b1;
      next_cycle();
      load_data = 4'b1111;
      for (int c = 0; c < W; c++) begin
         load_dir = ~load_dir;
         load_valid = (c < W - 1);
         @(negedge clk);
         got = {sout, last, load_ready};
         exp = {frame_bit(w, 1'b0, c), (c == W - 1), (c == W - 1)};
         total++;
         if (got !== exp)
            $display("FAIL midframe_bit%0d: got %b want %b", c, got, exp);
         else passed++;
         next_cycle();
      end
      load_valid = 1'b0;
      load_dir = 1'b0;
      next_cycle();
      load_data = w;
      load_valid = 1'b1;
      next_cycle();
      load_valid = 1'b0;
      next_cycle();
      #2;
      rst = 1'b1;
      #1;
      r = {sout, sout_valid, last, busy, load_ready};
      total++;
      if (r !== 5'b00001)
         $display("FAIL async_reset: got %b want 00001", r);
      else passed++;
      next_cycle();
      #2;
      rst = 1'b0;
      next_cycle();
      @(negedge clk);
      r = {sout, sout_valid, last, busy, load_ready};
      total++;
      if (r !== 5'b00001)
         $display("FAIL reset_discard: got %b want 00001", r);
      else passed++;
      next_cycle();
   endtask

   task automatic test_random();
      int q[$];
      logic exp_valid, exp_sout, exp_last, exp_ready;
      logic [4:0] got, exp;
      int errs = 0;
      for (int c = 0; c < 400; c++) begin
         en = ($urandom_range(0, 9) < 7);
         load_valid = ($urandom_range(0, 9) < 4);
         load_data = W'($urandom);
         load_dir = 1'($urandom);
         @(negedge clk);
         exp_valid = (q.size() > 0);
         exp_sout = exp_valid ? q[0][0] : 1'b0;
         exp_last = (q.size() == 1);
         exp_ready = (q.size() == 0) || (q.size() == 1 && en);
         got = {sout, sout_valid, last, busy, load_ready};
         exp = {exp_sout, exp_valid, exp_last, exp_valid, exp_ready};
         total++;
         if (got !== exp) begin
            errs++;
            if (errs <= 10)
               $display("FAIL random_cycle%0d: got %b want %b", c, got, exp);
         end else passed++;
         if (en && q.size() > 0) void'(q.pop_front());
         if (load_valid && exp_ready)
            for (int i = 0; i < W; i++)
               q.push_back(int'(frame_bit(load_data, load_dir, i)));
         next_cycle();
      end
      load_valid = 1'b0;
      en = 1'b1;
      repeat (W + 1) next_cycle();
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_pause();
      test_back_to_back();
      test_mid_frame();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
